// File: rtl/pulse_width_filter_pkg.sv
// Shared definitions for the pulse width filter: FSM state encoding and
// the helper that maps a state onto the filtered output level.
package pulse_width_filter_pkg;

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        QUAL_H = 2'd1,
        HIGH   = 2'd2,
        QUAL_L = 2'd3
    } state_t;

    // The filtered level stays high while a falling edge is still being qualified.
    function automatic logic level_of(input state_t st);
        return (st == HIGH) || (st == QUAL_L);
    endfunction

endpackage

// File: rtl/pulse_width_filter_sync_chain.sv
// N-flop synchroniser for bringing an asynchronous level into the clock domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_chain: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_width_filter.sv
// Synchronises a raw level, rejects pulses shorter than MIN_WIDTH samples and
// reports the sampled-high width of every accepted pulse.
module pulse_width_filter
    import pulse_width_filter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in,
    output logic             out,
    output logic             rise,
    output logic             fall,
    output logic             reject,
    output logic [CNT_W-1:0] width,
    output logic             width_valid,
    output logic [1:0]       dbg_state
);

    if (MIN_WIDTH < 2) begin : g_bad_min_width
        $error("pulse_width_filter: MIN_WIDTH must be at least 2");
    end
    if ((2 ** CNT_W) - 1 <= MIN_WIDTH) begin : g_bad_cnt_w
        $error("pulse_width_filter: CNT_W too narrow for MIN_WIDTH");
    end

    localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(MIN_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic s;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (in),
        .q     (s)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] qcnt_q, qcnt_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             reject_q, reject_d;
    logic             width_valid_q, width_valid_d;
    logic [CNT_W-1:0] wcnt_sat;

    // Pulse width sticks at the counter maximum rather than wrapping.
    assign wcnt_sat = (wcnt_q == CNT_MAX) ? wcnt_q : wcnt_q + CNT_ONE;

    always_comb begin
        state_d       = state_q;
        qcnt_d        = qcnt_q;
        wcnt_d        = wcnt_q;
        width_d       = width_q;
        rise_d        = 1'b0;
        fall_d        = 1'b0;
        reject_d      = 1'b0;
        width_valid_d = 1'b0;

        case (state_q)
            LOW: begin
                if (s) begin
                    state_d = QUAL_H;
                    qcnt_d  = CNT_ONE;
                    wcnt_d  = CNT_ONE;
                end
            end
            QUAL_H: begin
                if (!s) begin
                    state_d  = LOW;
                    reject_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_sat;
                    if (qcnt_q == QUAL_LAST) begin
                        state_d = HIGH;
                        rise_d  = 1'b1;
                    end else begin
                        qcnt_d = qcnt_q + CNT_ONE;
                    end
                end
            end
            HIGH: begin
                if (s) begin
                    wcnt_d = wcnt_sat;
                end else begin
                    state_d = QUAL_L;
                    qcnt_d  = CNT_ONE;
                end
            end
            QUAL_L: begin
                // A short low dip returns to HIGH silently; the dip cycles are not counted.
                if (s) begin
                    state_d = HIGH;
                    wcnt_d  = wcnt_sat;
                end else if (qcnt_q == QUAL_LAST) begin
                    state_d       = LOW;
                    fall_d        = 1'b1;
                    width_valid_d = 1'b1;
                    width_d       = wcnt_q;
                end else begin
                    qcnt_d = qcnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
            end
        endcase

        out_d = level_of(state_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= LOW;
            qcnt_q        <= '0;
            wcnt_q        <= '0;
            width_q       <= '0;
            out_q         <= 1'b0;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            reject_q      <= 1'b0;
            width_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            qcnt_q        <= qcnt_d;
            wcnt_q        <= wcnt_d;
            width_q       <= width_d;
            out_q         <= out_d;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            reject_q      <= reject_d;
            width_valid_q <= width_valid_d;
        end
    end

    assign out         = out_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign reject      = reject_q;
    assign width       = width_q;
    assign width_valid = width_valid_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pulse_width_filter.sv
// Randomised and directed bench for pulse_width_filter against a run-length
// reference model of the filtering rules.
module tb_pulse_width_filter;

    localparam int SYNC_STAGES = 2;
    localparam int MIN_WIDTH   = 4;
    localparam int CNT_W       = 8;
    localparam int WMAX        = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             in;
    logic             out;
    logic             rise;
    logic             fall;
    logic             reject;
    logic [CNT_W-1:0] width;
    logic             width_valid;
    logic [1:0]       dbg_state;

    pulse_width_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_WIDTH   (MIN_WIDTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in          (in),
        .out         (out),
        .rise        (rise),
        .fall        (fall),
        .reject      (reject),
        .width       (width),
        .width_valid (width_valid),
        .dbg_state   (dbg_state)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: filtered level plus run length of samples opposing it.
    bit pipe [SYNC_STAGES];
    bit m_lvl;
    int m_run;
    int m_ones;
    bit e_rise, e_fall, e_reject, e_wv;
    int e_width;

    // Observation tallies for directed checks.
    int cyc;
    int rise_cnt, fall_cnt, rej_cnt;
    int last_rise_cyc, last_fall_cyc, last_width;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step(input bit rst, input bit din);
        bit s;
        e_rise   = 1'b0;
        e_fall   = 1'b0;
        e_reject = 1'b0;
        e_wv     = 1'b0;
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) pipe[i] = 1'b0;
            m_lvl   = 1'b0;
            m_run   = 0;
            m_ones  = 0;
            e_width = 0;
            return;
        end
        s = pipe[SYNC_STAGES-1];
        for (int i = SYNC_STAGES - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = din;
        if (!m_lvl) begin
            if (s) begin
                m_run++;
                m_ones = (m_run == 1) ? 1 : ((m_ones == WMAX) ? m_ones : m_ones + 1);
                if (m_run == MIN_WIDTH) begin
                    m_lvl  = 1'b1;
                    e_rise = 1'b1;
                    m_run  = 0;
                end
            end else begin
                if (m_run > 0) e_reject = 1'b1;
                m_run = 0;
            end
        end else begin
            if (s) begin
                m_run  = 0;
                m_ones = (m_ones == WMAX) ? m_ones : m_ones + 1;
            end else begin
                m_run++;
                if (m_run == MIN_WIDTH) begin
                    m_lvl   = 1'b0;
                    e_fall  = 1'b1;
                    e_wv    = 1'b1;
                    e_width = m_ones;
                    m_run   = 0;
                end
            end
        end
    endtask

    task automatic tick(input bit rst, input bit din);
        reset = rst;
        in    = din;
        @(posedge clock);
        model_step(rst, din);
        #1;
        check("out", 32'(out), 32'(m_lvl));
        check("rise", 32'(rise), 32'(e_rise));
        check("fall", 32'(fall), 32'(e_fall));
        check("reject", 32'(reject), 32'(e_reject));
        check("width_valid", 32'(width_valid), 32'(e_wv));
        check("width", 32'(width), 32'(e_width));
        if (rise === 1'b1) begin
            rise_cnt++;
            last_rise_cyc = cyc;
        end
        if (fall === 1'b1) begin
            fall_cnt++;
            last_fall_cyc = cyc;
        end
        if (width_valid === 1'b1) last_width = int'(width);
        if (reject === 1'b1) rej_cnt++;
        cyc++;
    endtask

    task automatic pulse(input int hi, input int lo);
        repeat (hi) tick(1'b0, 1'b1);
        repeat (lo) tick(1'b0, 1'b0);
    endtask

    task automatic clear_tallies();
        rise_cnt   = 0;
        fall_cnt   = 0;
        rej_cnt    = 0;
        last_width = -1;
    endtask

    initial begin
        int c0;
        int hi, lo;
        cyc = 0;
        clear_tallies();
        reset = 1'b1;
        in    = 1'b0;
        repeat (3) tick(1'b1, 1'b0);
        check("reset_out", 32'(out), 32'd0);
        check("reset_width", 32'(width), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        repeat (4) tick(1'b0, 1'b0);

        // Short glitch is rejected once with no rise.
        clear_tallies();
        pulse(3, 12);
        check("t2_reject_cnt", 32'(rej_cnt), 32'd1);
        check("t2_rise_cnt", 32'(rise_cnt), 32'd0);

        // Exactly MIN_WIDTH samples accepted.
        clear_tallies();
        pulse(4, 12);
        check("t6_rise_cnt", 32'(rise_cnt), 32'd1);
        check("t6_width", 32'(last_width), 32'd4);
        check("t6_reject_cnt", 32'(rej_cnt), 32'd0);

        // Clean 10-cycle pulse: latency and width.
        clear_tallies();
        c0 = cyc;
        pulse(10, 12);
        check("t3_rise_latency", 32'(last_rise_cyc - c0), 32'd5);
        check("t3_fall_latency", 32'(last_fall_cyc - (c0 + 10)), 32'd5);
        check("t3_width", 32'(last_width), 32'd10);

        // Low dip inside a pulse is absorbed.
        clear_tallies();
        pulse(10, 2);
        pulse(8, 12);
        check("t4_rise_cnt", 32'(rise_cnt), 32'd1);
        check("t4_fall_cnt", 32'(fall_cnt), 32'd1);
        check("t4_width", 32'(last_width), 32'd18);

        // Width saturates instead of wrapping.
        clear_tallies();
        pulse(300, 12);
        check("t5_width_sat", 32'(last_width), 32'(WMAX));

        // Reset while the filtered level is high.
        clear_tallies();
        pulse(10, 0);
        check("t1_out_high", 32'(out), 32'd1);
        tick(1'b1, 1'b1);
        check("t1_out_after_reset", 32'(out), 32'd0);
        check("t1_width_after_reset", 32'(width), 32'd0);
        pulse(0, 12);
        check("t1_no_fall", 32'(fall_cnt), 32'd0);

        // Random pulse trains with occasional long pulses and resets.
        for (int k = 0; k < 400; k++) begin
            hi = ($urandom_range(0, 19) == 0) ? int'($urandom_range(200, 280))
                                              : int'($urandom_range(1, 9));
            lo = int'($urandom_range(1, 9));
            if ($urandom_range(0, 49) == 0) begin
                tick(1'b1, 1'($urandom_range(0, 1)));
            end
            pulse(hi, lo);
        end
        pulse(0, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
